// File: rtl/rib_arbiter.sv
// rib_arbiter: registered round-robin arbiter holding each grant for a full RIB transaction
module rib_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  input  logic       s_ack,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic [3:0] m_ack,
  output logic [3:0] hold,
  output logic       timeout_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [1:0] last_id, last_id_n, grant_id_n, base, win_id;
  logic [3:0] grant_n, cand;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic timeout_err_n, win, keep, expire, rel;
  // round-robin search from the pointer; while busy the current owner is excluded
  always_comb begin
    base = state == BUSY ? grant_id : last_id;
    cand = state == BUSY ? req & ~grant : req;
    win = 1'b0;
    win_id = 2'b00;
    for (int k = 4; k >= 1; k--)
      if (cand[base + 2'(k)]) begin
        win = 1'b1;
        win_id = base + 2'(k);
      end
  end
  // transaction end conditions for the current owner
  always_comb begin
    keep = s_ack & lock[grant_id] & req[grant_id];
    expire = ~s_ack & (cnt == CNT_W'(TIMEOUT - 1));
    rel = s_ack ? ~keep : (~req[grant_id] | expire);
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      last_id <= 2'd3;
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_id <= grant_id_n;
      last_id <= last_id_n;
      cnt <= cnt_n;
      timeout_err <= timeout_err_n;
    end
  // next-state logic: grant, hold under lock, hand over or fall back to idle
  always_comb begin
    state_n = state;
    grant_n = grant;
    grant_id_n = grant_id;
    last_id_n = last_id;
    cnt_n = cnt;
    timeout_err_n = 1'b0;
    if (state == IDLE) begin
      if (win) begin
        state_n = BUSY;
        grant_n = 4'b0001 << win_id;
        grant_id_n = win_id;
        cnt_n = '0;
      end
    end else if (rel) begin
      last_id_n = grant_id;
      timeout_err_n = expire;
      cnt_n = '0;
      if (win) begin
        grant_n = 4'b0001 << win_id;
        grant_id_n = win_id;
      end else begin
        state_n = IDLE;
        grant_n = '0;
      end
    end else
      cnt_n = keep ? '0 : cnt + CNT_W'(1);
  end
  // zero-latency acknowledge and stall outputs
  always_comb begin
    grant_valid = state == BUSY;
    m_ack = {4{s_ack}} & grant;
    hold = req & ~grant;
  end
endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed and randomized checks of rib_arbiter against a transaction-level model
module tb_rib_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, lock;
  logic s_ack;
  logic [3:0] grant, m_ack, hold;
  logic [1:0] grant_id;
  logic grant_valid, timeout_err;
  int passed = 0, total = 0;
  bit m_busy, m_terr;
  int m_gid, m_last, m_age;

  rib_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .s_ack(s_ack),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid),
    .m_ack(m_ack), .hold(hold), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int pick(int from, logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_last = 3; m_age = 0; m_terr = 0;
  endtask

  // one bus cycle of the transaction-level model, using the inputs just applied
  task automatic model_step();
    int w;
    logic [3:0] m;
    bit stay, to, done;
    m_terr = 0;
    if (!m_busy) begin
      w = pick(m_last, req);
      if (w >= 0) begin m_busy = 1; m_gid = w; m_age = 0; end
    end else begin
      stay = s_ack && lock[m_gid] && req[m_gid];
      to = !s_ack && m_age == TO - 1;
      done = (s_ack && !stay) || (!s_ack && !req[m_gid]) || to;
      if (stay) m_age = 0;
      else if (done) begin
        m_terr = to;
        m_last = m_gid;
        m = req;
        m[m_gid] = 1'b0;
        w = pick(m_last, m);
        if (w >= 0) begin m_gid = w; m_age = 0; end
        else m_busy = 0;
      end else m_age++;
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic a);
    model_step();
    @(negedge clk);
    req = r; lock = l; s_ack = a;
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = 0; lock = 0; s_ack = 0;
    #2;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1; req = 0; lock = 0; s_ack = 0;
    #12;
    total++; if ({grant, grant_valid, timeout_err} !== 6'b0) $display("FAIL reset_state: got %b want 000000", {grant, grant_valid, timeout_err}); else passed++;
    rst = 0;
    model_reset();
    drive(4'b1111, 4'b0, 1'b0);
    total++; if (grant !== 4'b0000) $display("FAIL reset_idle_grant: got %b want 0000", grant); else passed++;
    drive(4'b1111, 4'b0, 1'b1);
    total++; if ({grant, m_ack} !== 8'b0001_0001) $display("FAIL reset_first_grant: got %b want 00010001", {grant, m_ack}); else passed++;
    #1 rst = 1;
    #1;
    total++; if ({grant, grant_valid, m_ack, hold, timeout_err} !== 14'b0000_0_0000_1111_0) $display("FAIL async_reset: got %b want 00000000011110", {grant, grant_valid, m_ack, hold, timeout_err}); else passed++;
    #1 rst = 0; req = 0; s_ack = 0;
    model_reset();
    drive(4'b1111, 4'b0, 1'b0);
    drive(4'b1111, 4'b0, 1'b0);
    total++; if (grant !== 4'b0001) $display("FAIL reset_priority: got %b want 0001", grant); else passed++;
  endtask

  task automatic test_rotation();
    logic [3:0] eg;
    do_reset();
    drive(4'b1111, 4'b0, 1'b1);
    total++; if ({grant, m_ack} !== 8'b0) $display("FAIL rot_idle: got %b want 00000000", {grant, m_ack}); else passed++;
    for (int i = 0; i < 9; i++) begin
      drive(4'b1111, 4'b0, 1'b1);
      eg = 4'b0001 << (i % 4);
      total++; if ({grant, hold, m_ack} !== {eg, ~eg, eg}) $display("FAIL rotation cycle %0d: got %b want %b", i, {grant, hold, m_ack}, {eg, ~eg, eg}); else passed++;
    end
  endtask

  task automatic test_lock();
    logic [3:0] eg_t [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] lk_t [7] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    drive(4'b1111, 4'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(4'b1111, lk_t[i], 1'b1);
      total++; if ({grant, m_ack} !== {eg_t[i], eg_t[i]}) $display("FAIL lock cycle %0d: got %b want %b", i, {grant, m_ack}, {eg_t[i], eg_t[i]}); else passed++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(4'b0010, 4'b0, 1'b0);
    for (int i = 0; i < TO; i++) begin
      drive(4'b0011, 4'b0, 1'b0);
      total++; if ({grant, m_ack, timeout_err} !== 9'b0010_0000_0) $display("FAIL timeout_wait cycle %0d: got %b want 001000000", i, {grant, m_ack, timeout_err}); else passed++;
    end
    drive(4'b0011, 4'b0, 1'b0);
    total++; if ({grant, timeout_err} !== 5'b0001_1) $display("FAIL timeout_pulse: got %b want 00011", {grant, timeout_err}); else passed++;
    drive(4'b0011, 4'b0, 1'b0);
    total++; if (timeout_err !== 1'b0) $display("FAIL timeout_one_cycle: got %b want 0", timeout_err); else passed++;
  endtask

  task automatic test_abandon();
    do_reset();
    drive(4'b1000, 4'b0, 1'b0);
    drive(4'b1000, 4'b0, 1'b0);
    total++; if (grant !== 4'b1000) $display("FAIL abandon_grant: got %b want 1000", grant); else passed++;
    drive(4'b0000, 4'b0, 1'b0);
    total++; if ({grant, m_ack} !== 8'b1000_0000) $display("FAIL abandon_drop: got %b want 10000000", {grant, m_ack}); else passed++;
    drive(4'b0000, 4'b0, 1'b0);
    total++; if ({grant, grant_valid, timeout_err} !== 6'b0) $display("FAIL abandon_idle: got %b want 000000", {grant, grant_valid, timeout_err}); else passed++;
    do_reset();
    drive(4'b0010, 4'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) drive(4'b0010, 4'b0, 1'b0);
    drive(4'b0010, 4'b0, 1'b1);
    total++; if ({grant, m_ack} !== 8'b0010_0010) $display("FAIL simul_ack: got %b want 00100010", {grant, m_ack}); else passed++;
    drive(4'b0000, 4'b0, 1'b0);
    total++; if ({grant, grant_valid, timeout_err} !== 6'b0) $display("FAIL simul_no_timeout: got %b want 000000", {grant, grant_valid, timeout_err}); else passed++;
  endtask

  task automatic test_idle_ack();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'b0, 1'b1);
      total++; if ({grant, grant_valid, m_ack} !== 9'b0) $display("FAIL idle_ack cycle %0d: got %b want 000000000", i, {grant, grant_valid, m_ack}); else passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic [14:0] exp_v, got_v;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive(4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0);
      eg = m_busy ? 4'b0001 << m_gid : 4'b0000;
      exp_v = {eg, m_busy, s_ack ? eg : 4'b0000, req & ~eg, m_terr, m_busy ? 1'b1 : 1'b0};
      got_v = {grant, grant_valid, m_ack, hold, timeout_err, grant_valid ? (grant_id == 2'(m_gid)) : 1'b0};
      total++; if (got_v !== exp_v) $display("FAIL random cycle %0d: got %b want %b", i, got_v, exp_v); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_lock();
    test_timeout();
    test_abandon();
    test_idle_ack();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
